// File: rtl/fetch_pipe_ctrl.sv
// Fetch-stage controller: owns the PC and the IF/ID register and applies
// hazard-unit stall/flush requests. It also keeps stall and flush statistics.
module fetch_pipe_ctrl #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR   = 32'h0000_0013,
  parameter int unsigned STALL_LIMIT = 15
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        flush,
  input  logic [31:0] branch_target,
  input  logic [31:0] imem_rdata,
  output logic [31:0] imem_addr,
  output logic [31:0] if_id_pc,
  output logic [31:0] if_id_instr,
  output logic        if_id_valid,
  output logic        kill_id_ex,
  output logic        stall_timeout,
  output logic [15:0] stall_cnt,
  output logic [15:0] flush_cnt
);

  typedef enum logic [1:0] {
    S_RUN,
    S_STALL,
    S_FLUSH
  } state_e;

  localparam logic [7:0] RUN_LIMIT = 8'(STALL_LIMIT);

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] if_id_pc_q, if_id_pc_d;
  logic [31:0] if_id_instr_q, if_id_instr_d;
  logic        if_id_valid_q, if_id_valid_d;
  logic        timeout_q, timeout_d;
  logic [15:0] stall_cnt_q, stall_cnt_d;
  logic [15:0] flush_cnt_q, flush_cnt_d;
  logic [7:0]  run_q, run_d;

  // Flush has priority over stall; the FSM state only adds the ID/EX kill.
  always_comb begin
    // NOTE: every _d gets a hold default first so no path leaves a latch.
    state_d       = S_RUN;
    pc_d          = pc_q;
    if_id_pc_d    = if_id_pc_q;
    if_id_instr_d = if_id_instr_q;
    if_id_valid_d = if_id_valid_q;
    timeout_d     = timeout_q;
    stall_cnt_d   = stall_cnt_q;
    flush_cnt_d   = flush_cnt_q;
    run_d         = run_q;

    if (flush) begin
      state_d       = S_FLUSH;
      pc_d          = branch_target & 32'hFFFF_FFFC;
      if_id_instr_d = NOP_INSTR;
      if_id_valid_d = 1'b0;
      flush_cnt_d   = (flush_cnt_q == 16'hFFFF) ? flush_cnt_q : flush_cnt_q + 16'd1;
      run_d         = 8'd0;
    end else if (stall) begin
      state_d     = S_STALL;
      stall_cnt_d = (stall_cnt_q == 16'hFFFF) ? stall_cnt_q : stall_cnt_q + 16'd1;
      run_d       = (run_q == 8'hFF) ? run_q : run_q + 8'd1;
      if (run_d == RUN_LIMIT) timeout_d = 1'b1;
    end else begin
      state_d       = S_RUN;
      if_id_instr_d = imem_rdata;
      if_id_pc_d    = pc_q;
      if_id_valid_d = 1'b1;
      pc_d          = pc_q + 32'd4;
      run_d         = 8'd0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers
  // update together from the same pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_RUN;
      pc_q          <= RESET_PC;
      if_id_pc_q    <= 32'd0;
      if_id_instr_q <= NOP_INSTR;
      if_id_valid_q <= 1'b0;
      timeout_q     <= 1'b0;
      stall_cnt_q   <= 16'd0;
      flush_cnt_q   <= 16'd0;
      run_q         <= 8'd0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      if_id_pc_q    <= if_id_pc_d;
      if_id_instr_q <= if_id_instr_d;
      if_id_valid_q <= if_id_valid_d;
      timeout_q     <= timeout_d;
      stall_cnt_q   <= stall_cnt_d;
      flush_cnt_q   <= flush_cnt_d;
      run_q         <= run_d;
    end
  end

  assign imem_addr     = pc_q;
  assign if_id_pc      = if_id_pc_q;
  assign if_id_instr   = if_id_instr_q;
  assign if_id_valid   = if_id_valid_q;
  assign kill_id_ex    = (state_q == S_FLUSH);
  assign stall_timeout = timeout_q;
  assign stall_cnt     = stall_cnt_q;
  assign flush_cnt     = flush_cnt_q;

endmodule

// File: doc/fetch_pipe_ctrl.md
FETCH_PIPE_CTRL -- requirements
Module: fetch_pipe_ctrl

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, is the PC value loaded at reset.
REQ-002 Parameter NOP_INSTR, default 32'h0000_0013, is the bubble instruction written into IF/ID.
REQ-003 Parameter STALL_LIMIT, default 15 (range 1..255), is the number of consecutive stall cycles that sets the timeout flag.
REQ-004 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-005 clk  in  1  rising-edge clock.
REQ-006 rst_n  in  1  asynchronous active-low reset.
REQ-007 stall  in  1  hazard unit request to freeze PC and IF/ID.
REQ-008 flush  in  1  hazard unit request to redirect fetch and squash younger instructions.
REQ-009 branch_target  in  32  redirect address, sampled when flush=1.
REQ-010 imem_rdata  in  32  instruction at imem_addr, valid in the same cycle.
REQ-011 imem_addr  out  32  current PC, combinational from the PC register.
REQ-012 if_id_pc  out  32  registered PC of the instruction in IF/ID.
REQ-013 if_id_instr  out  32  registered instruction in IF/ID.
REQ-014 if_id_valid  out  1  IF/ID holds a real instruction (0 = bubble).
REQ-015 kill_id_ex  out  1  registered; forces a bubble into ID/EX for one cycle after a flush.
REQ-016 stall_timeout  out  1  sticky flag: STALL_LIMIT consecutive stall cycles have occurred.
REQ-017 stall_cnt  out  16  total stalled cycles, saturating.
REQ-018 flush_cnt  out  16  total flush events, saturating.

Function
REQ-019 FSM states SHALL be RUN, STALL and FLUSH, and all state changes SHALL occur on the rising clk edge.
REQ-020 In any state with flush=1: pc<=branch_target with bits [1:0] forced to 0, if_id_instr<=NOP_INSTR, if_id_valid<=0, next state FLUSH, flush_cnt increments, and the consecutive-stall run counter clears.
REQ-021 With flush=1 and stall=1 in the same cycle, flush SHALL win, and stall_cnt SHALL NOT increment.
REQ-022 With stall=1 and flush=0: pc, if_id_pc, if_id_instr and if_id_valid hold, next state STALL, stall_cnt increments, and the run counter increments (saturating at 255).
REQ-023 When the run counter reaches STALL_LIMIT, stall_timeout SHALL set on that edge and remain 1 until reset.
REQ-024 With stall=0 and flush=0: if_id_instr<=imem_rdata, if_id_pc<=pc, if_id_valid<=1, pc<=pc+4, next state RUN, and the run counter clears.
REQ-025 PC increment SHALL be modulo 2^32, so 32'hFFFF_FFFC advances to 32'h0000_0000.
REQ-026 kill_id_ex SHALL be 1 exactly in cycles where state==FLUSH; back-to-back flushes keep it 1 continuously.
REQ-027 Fetch behaviour in FLUSH SHALL follow REQ-020/022/024; FLUSH only adds kill_id_ex.
REQ-028 stall_cnt and flush_cnt SHALL saturate at 16'hFFFF and never wrap.
REQ-029 Latency: the instruction at the redirected PC SHALL appear in IF/ID on the second edge after flush is sampled, absent stalls.

Reset
REQ-030 On rst_n=0, asynchronously: pc=RESET_PC, if_id_pc=0, if_id_instr=NOP_INSTR, if_id_valid=0, kill_id_ex=0, stall_timeout=0, stall_cnt=0, flush_cnt=0, run counter=0, state RUN.
REQ-031 Reset asserted mid-stall or mid-flush SHALL override all inputs immediately.
REQ-032 The first fetch after rst_n rises SHALL occur on the first rising edge with rst_n=1.

Verification
REQ-033 Reset release, no stall/flush, imem returns addr-based data for 3 cycles -> if_id_pc 0,4,8; if_id_valid=1 from the first edge; imem_addr=12.
REQ-034 stall=1 for 4 cycles at pc=8 -> IF/ID and imem_addr frozen; stall_cnt=4; state returns to RUN the cycle after stall drops.
REQ-035 flush=1 with branch_target=32'h0000_0103 -> pc=32'h100, if_id_instr=32'h13, if_id_valid=0, kill_id_ex=1 for one cycle, flush_cnt=1.
REQ-036 flush=1 and stall=1 simultaneously -> redirect taken, stall_cnt unchanged.
REQ-037 stall held 15 cycles -> stall_timeout=1 on the 15th edge and still 1 after stall drops; rst_n pulse -> cleared.
REQ-038 pc=32'hFFFF_FFFC with no stall/flush -> pc becomes 0 and if_id_pc=32'hFFFF_FFFC.
